// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store unit (master) and the data
// memory responder (slave). One request in flight at a time.
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  // Requester side (LSU / testbench)
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side (memory)
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_STATES extra cycles
// between accept and response, byte-lane memory with registered read,
// aligned and sign/zero-extended load data, error flag for bad accesses.
// The lane decode assumes a 32-bit word (addr[1:0] selects the byte lane).
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dmem_responder_if.slave    bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam int CW = 4;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_wait_cnt;
  logic [CW-1:0]   w_wait_cnt_next;
  logic            w_req_ready;
  logic            w_rsp_valid;

  // Request fields latched at accept
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [XLEN-1:0] r_wdata;

  // Fields used by the commit edge: live inputs when jumping straight from
  // IDLE to RESP, latched copies when coming out of WAIT.
  logic            w_c_we;
  logic [XLEN-1:0] w_c_addr;
  logic [1:0]      w_c_size;
  logic [XLEN-1:0] w_c_wdata;
  logic            w_c_err;
  logic [AW-1:0]   w_c_idx;
  logic            w_commit;

  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_rd_word;
  logic            w_r_err;
  logic [7:0]      w_rd_byte;
  logic [15:0]     w_rd_half;
  logic [XLEN-1:0] w_rdata;

  // Error decode: illegal size, misalignment, or address beyond the array.
  function automatic logic f_access_err(input logic [XLEN-1:0] addr,
                                        input logic [1:0]      size);
    logic oor;
    oor = ((addr >> (AW + 2)) != '0);
    case (size)
      2'b00:   return oor;
      2'b01:   return oor | addr[0];
      2'b10:   return oor | (addr[1:0] != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Next-state and handshake outputs
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_req_ready     = 1'b0;
    w_rsp_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = !i_rst;
        if (bus.req_valid && !i_rst) begin
          w_wait_cnt_next = '0;
          w_state_next    = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = ST_RESP;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register and wait-state counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Capture the request on the accept cycle only; later input changes are ignored
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
    end else if (w_req_ready && bus.req_valid) begin
      r_we       <= bus.req_we;
      r_addr     <= bus.req_addr;
      r_size     <= bus.req_size;
      r_unsigned <= bus.req_unsigned;
      r_wdata    <= bus.req_wdata;
    end
  end

  assign w_c_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
  assign w_c_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_c_size  = (r_state == ST_IDLE) ? bus.req_size  : r_size;
  assign w_c_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;
  assign w_c_err   = f_access_err(w_c_addr, w_c_size);
  assign w_c_idx   = w_c_addr[AW+1:2];

  // The access happens exactly once, on the edge that enters RESP.
  assign w_commit = !i_rst && (w_state_next == ST_RESP) && (r_state != ST_RESP);

  // One byte-wide memory per lane so each lane has its own write enable.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] r_mem [0:DEPTH_WORDS-1];
    logic [7:0] r_rd;
    logic [7:0] w_wbyte;
    logic       w_lane_hit;

    always_comb begin
      w_lane_hit = 1'b0;
      w_wbyte    = w_c_wdata[8*gi +: 8];
      case (w_c_size)
        2'b00: begin
          w_lane_hit = (w_c_addr[1:0] == 2'(gi));
          w_wbyte    = w_c_wdata[7:0];
        end
        2'b01: begin
          w_lane_hit = (w_c_addr[1] == 1'(gi / 2));
          w_wbyte    = w_c_wdata[8*(gi % 2) +: 8];
        end
        2'b10: begin
          w_lane_hit = 1'b1;
          w_wbyte    = w_c_wdata[8*gi +: 8];
        end
        default: begin
          w_lane_hit = 1'b0;
        end
      endcase
    end

    assign w_be[gi] = w_c_we && !w_c_err && w_lane_hit;

    // Lane write with byte enable and registered read of the addressed word
    always_ff @(posedge i_clk) begin
      if (w_commit) begin
        if (w_be[gi]) begin
          r_mem[w_c_idx] <= w_wbyte;
        end
        r_rd <= r_mem[w_c_idx];
      end
    end

    assign w_rd_word[8*gi +: 8] = r_rd;
  end

  // Response formatting from the latched request and the registered word
  assign w_r_err   = f_access_err(r_addr, r_size);
  assign w_rd_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  // Lane select for byte loads
  always_comb begin
    w_rd_byte = w_rd_word[7:0];
    case (r_addr[1:0])
      2'b00:   w_rd_byte = w_rd_word[7:0];
      2'b01:   w_rd_byte = w_rd_word[15:8];
      2'b10:   w_rd_byte = w_rd_word[23:16];
      default: w_rd_byte = w_rd_word[31:24];
    endcase
  end

  // Extension; stores, errors and non-RESP cycles read as zero
  always_comb begin
    w_rdata = '0;
    if ((r_state == ST_RESP) && !r_we && !w_r_err) begin
      case (r_size)
        2'b00: begin
          w_rdata = r_unsigned ? {{(XLEN-8){1'b0}}, w_rd_byte}
                               : {{(XLEN-8){w_rd_byte[7]}}, w_rd_byte};
        end
        2'b01: begin
          w_rdata = r_unsigned ? {{(XLEN-16){1'b0}}, w_rd_half}
                               : {{(XLEN-16){w_rd_half[15]}}, w_rd_half};
        end
        default: begin
          w_rdata = w_rd_word;
        end
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rdata;
  assign bus.rsp_err   = (r_state == ST_RESP) && w_r_err;

endmodule
